// File: rtl/if_fetch_buf.sv
// Instruction fetch stage: single-outstanding instruction bus requests feeding a prefetch FIFO read by ID.
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt outputs.
//   state     | meaning
//   S_RUN     | free to issue the next fetch, or push a pending misaligned-target entry
//   S_WAIT    | request outstanding, waiting for ibus_ack
//   S_DISCARD | response still outstanding but its data is unwanted
//   S_HALT    | fault or interrupt taken, idle until pip_flush
module if_fetch_buf #(
  parameter int                     IADDR_WIDTH = 64,
  parameter int                     FIFO_DEPTH  = 4,
  parameter logic [IADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pip_flush,
  input  logic [IADDR_WIDTH-1:0] flush_pc,
  input  logic                   int_req,
  output logic                   ibus_req,
  output logic [IADDR_WIDTH-1:0] ibus_addr,
  input  logic                   ibus_ack,
  input  logic [31:0]            ibus_rdata,
  input  logic                   ibus_err,
  input  logic                   ibus_pf,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_ins,
  output logic [IADDR_WIDTH-1:0] id_pc,
  output logic                   id_ins_acc_fault,
  output logic                   id_ins_page_fault,
  output logic                   id_ins_addr_mis,
  output logic                   id_int_acc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_drop_cnt
`endif
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DISCARD, S_HALT} state_t;

  state_t                 state, state_nxt;
  logic [IADDR_WIDTH-1:0] fetch_pc;
  ptr_t                   rd_ptr, wr_ptr;
  cnt_t                   count;
  logic                   mis_pend, int_tag, halt_after;
  logic                   ack_push, mis_push, ack_drop, int_take;
  logic                   push, pop, has_room;

  logic [31:0]            mem_ins [FIFO_DEPTH];
  logic [IADDR_WIDTH-1:0] mem_pc  [FIFO_DEPTH];
  logic [2:0]             mem_tag [FIFO_DEPTH];

  assign id_valid  = (count != '0);
  assign pop       = id_valid & id_ready;
  assign has_room  = (count < cnt_t'(FIFO_DEPTH));
  assign push      = ack_push | mis_push;
  assign ibus_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ibus_req  = 1'b0;
    ack_push  = 1'b0;
    mis_push  = 1'b0;
    ack_drop  = 1'b0;
    int_take  = id_valid & int_req & ((state == S_RUN) | (state == S_WAIT));
    case (state)
      S_RUN: begin
        if (mis_pend) begin
          mis_push  = 1'b1;
          state_nxt = S_HALT;
        end else if (int_take) begin
          state_nxt = S_HALT;
        end else if (has_room) begin
          ibus_req  = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        ibus_req = 1'b1;
        // Interrupt taken mid-fetch: the response still has to be swallowed before halting
        if (int_take) begin
          ack_drop  = ibus_ack;
          state_nxt = ibus_ack ? S_HALT : S_DISCARD;
        end else if (ibus_ack) begin
          ack_push  = 1'b1;
          state_nxt = (ibus_err | ibus_pf) ? S_HALT : S_RUN;
        end
      end
      S_DISCARD: begin
        if (ibus_ack) begin
          ack_drop  = 1'b1;
          state_nxt = halt_after ? S_HALT : S_RUN;
        end
      end
      default: ;
    endcase
    if (pip_flush) begin
      if (state == S_RUN) ibus_req = 1'b0;
      ack_push  = 1'b0;
      mis_push  = 1'b0;
      int_take  = 1'b0;
      ack_drop  = ibus_ack & ((state == S_WAIT) | (state == S_DISCARD));
      state_nxt = (((state == S_WAIT) | (state == S_DISCARD)) & ~ibus_ack) ? S_DISCARD : S_RUN;
    end
    if (rst) begin
      ibus_req  = 1'b0;
      ack_push  = 1'b0;
      mis_push  = 1'b0;
      ack_drop  = 1'b0;
      int_take  = 1'b0;
      state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      mis_pend   <= 1'b0;
      int_tag    <= 1'b0;
      halt_after <= 1'b0;
    end else if (pip_flush) begin
      fetch_pc   <= flush_pc;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      mis_pend   <= |flush_pc[1:0];
      int_tag    <= 1'b0;
      halt_after <= 1'b0;
    end else begin
      if (ack_push) fetch_pc <= fetch_pc + IADDR_WIDTH'(4);
      if (mis_push) mis_pend <= 1'b0;
      if (state == S_DISCARD && ibus_ack) halt_after <= 1'b0;
      // On interrupt keep only the tagged head; everything behind it is dropped
      if (int_take) begin
        halt_after <= (state == S_WAIT) & ~ibus_ack;
        int_tag    <= ~pop;
        wr_ptr     <= rd_ptr + ptr_t'(1);
        count      <= pop ? cnt_t'(0) : cnt_t'(1);
        if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + ptr_t'(1);
          int_tag <= 1'b0;
        end
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= fetch_pc;
      if (mis_push) begin
        mem_ins[wr_ptr] <= NOP;
        mem_tag[wr_ptr] <= 3'b001;
      end else begin
        mem_ins[wr_ptr] <= (ibus_err | ibus_pf) ? NOP : ibus_rdata;
        mem_tag[wr_ptr] <= {ibus_err, ibus_pf, 1'b0};
      end
    end
  end

  assign id_ins     = id_valid ? mem_ins[rd_ptr] : 32'h0;
  assign id_pc      = id_valid ? mem_pc[rd_ptr] : '0;
  assign {id_ins_acc_fault, id_ins_page_fault, id_ins_addr_mis} = id_valid ? mem_tag[rd_ptr] : 3'b000;
  assign id_int_acc = id_valid & (int_tag | int_take);

`ifdef IF_PERF_CNT_EN
  logic [31:0] flush_clr;
  assign flush_clr = pip_flush ? 32'(count - cnt_t'(pop)) : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_drop_cnt  <= 32'h0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(ack_push);
      perf_drop_cnt  <= perf_drop_cnt + 32'(ack_drop) + flush_clr;
    end
  end
`endif

endmodule
